// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and the reader FSM state type.
package fifo_pkg;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDRESS_SIZE = 4;
  localparam int DEF_BURST_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fifo_reader_state_t;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry in-order valid/ready buffer; out_data is the head, skid holds the second word.
module fifo_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] skid;
  logic xfer;
  assign out_valid = count != 2'd0;
  assign xfer = out_valid & out_ready;
  // The producer never offers a word to a full buffer that is not draining.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      out_data <= '0;
      skid <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + {1'b0, in_valid} - {1'b0, xfer};
      if (xfer && count == 2'd2) out_data <= skid;
      else if (in_valid && (count == 2'd0 || xfer)) out_data <= in_data;
      if (in_valid && (count == 2'd2 ? xfer : count == 2'd1 && !xfer)) skid <= in_data;
    end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a burst of words from the FIFO and streams them out over valid/ready.
// Define FIFO_READER_PARITY_EN to add m_parity (^m_data, registered with the data).
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_pop,
  output logic                 fifo_can_read,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic                 m_parity
`endif
);
  fifo_reader_state_t state, state_n;
  logic [BURST_W-1:0] issue_left, accept_left;
  logic [1:0] stored;
  logic inflight, zero_done, xfer, start_ok, flush, last_accept;
  assign start_ok = start & !abort & state == IDLE & !zero_done;
  assign flush = abort & state != IDLE;
  assign xfer = m_valid & m_ready;
  assign last_accept = state == DRAIN & xfer & accept_left == BURST_W'(1);
  // Stored plus in-flight words after this cycle's transfer must leave room for one more pop.
  assign fifo_pop = state == RUN & !abort & !fifo_empty & issue_left != '0 &
                    ({1'b0, stored} + {2'b0, inflight} - {2'b0, xfer}) < 3'd2;
  assign fifo_can_read = fifo_pop;
  assign done = last_accept | zero_done;
  assign busy = state != IDLE | zero_done;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (start_ok) state_n = burst_len != '0 ? RUN : IDLE;
    else if (state == RUN && fifo_pop && issue_left == BURST_W'(1)) state_n = DRAIN;
    else if (last_accept) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      issue_left <= '0;
      accept_left <= '0;
      inflight <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= fifo_pop;
      zero_done <= start_ok & burst_len == '0;
      if (start_ok) begin
        issue_left <= burst_len;
        accept_left <= burst_len;
      end else begin
        if (fifo_pop) issue_left <= issue_left - BURST_W'(1);
        if (xfer && accept_left != '0) accept_left <= accept_left - BURST_W'(1);
      end
    end
`ifdef FIFO_READER_PARITY_EN
  fifo_skid_buf #(.W(DATA_SIZE + 1)) u_buf (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inflight), .in_data({^fifo_data, fifo_data}),
    .out_valid(m_valid), .out_ready(m_ready), .out_data({m_parity, m_data}),
    .count(stored)
  );
`else
  fifo_skid_buf #(.W(DATA_SIZE)) u_buf (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inflight), .in_data(fifo_data),
    .out_valid(m_valid), .out_ready(m_ready), .out_data(m_data),
    .count(stored)
  );
`endif
endmodule
